mux_nx1_rr: RTL and testbench
=============================

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, select/channel-index width; SHALL satisfy 2^SEL_W >= N.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready; combinational; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-010 sel  input  SEL_W  channel index, used only when mode=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds a valid word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid=1.

Function
REQ-015 Output stage SHALL be a single-entry register; load_en = !out_valid || out_ready.
REQ-016 Mode 0: grant channel sel when load_en=1 and in_valid[sel]=1; when sel >= N, no grant.
REQ-017 Mode 1: grant the first channel with in_valid=1 when searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrapping modulo N).
REQ-018 in_ready[g] SHALL be 1 only for the granted channel g, and only when load_en=1; all other bits are 0.
REQ-019 A transfer on channel g occurs when in_valid[g] && in_ready[g].
REQ-020 On a transfer, out_data <= in_data[g], out_chan <= g and out_valid <= 1 on the next edge; latency is one cycle.
REQ-021 If out_valid && out_ready and there is no transfer in the same cycle, out_valid <= 0; out_data and out_chan hold their values.
REQ-022 Simultaneous drain and load in one cycle SHALL sustain one word per cycle with no bubble.
REQ-023 While out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold, and all in_ready bits are 0.
REQ-024 ptr (SEL_W bits) SHALL update to (g+1) mod N only on a mode-1 transfer; it holds in mode 0.
REQ-025 A change of mode or sel SHALL take effect on the grant computed in the same cycle; it does not disturb a word already held in the output register.
REQ-026 No channel SHALL starve in mode 1: a continuously valid channel is granted within N transfers.

Reset
REQ-027 While rst=1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0 and ptr <= 0.
REQ-028 While rst=1, in_ready SHALL be all zeros regardless of other inputs.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; no transfer is counted in that cycle.

Verification (N=4, WIDTH=8)
REQ-030 Reset test: rst=1 for 2 cycles with in_valid=4'b1111 and out_ready=1 -> out_valid=0, out_data=8'h00, out_chan=0, in_ready=4'b0000.
REQ-031 Fixed-select test: mode=0, sel=2, channel 2 data=8'hA5 valid, out_ready=1 -> in_ready=4'b0100, and on the next cycle out_data=8'hA5, out_chan=2, out_valid=1.
REQ-032 Round-robin test: mode=1, all channels valid, out_ready=1 held -> out_chan sequence is 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-033 Sparse round-robin test: mode=1, in_valid=4'b1010, starting from ptr=0 -> grants are 1, 3, 1, 3.
REQ-034 Backpressure test: word 8'h3C held, out_ready=0 for 3 cycles -> out_data stays 8'h3C and in_ready=0 throughout; out_ready=1 -> the next word loads in the same cycle.
REQ-035 Edge-case test: mode=0 with sel=5 (N=4) -> no grant and in_ready=0; separately, rst pulsed while out_valid=1 -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 channel multiplexer with a single-entry registered output.
// The grant comes either from a fixed select or from a round-robin search that
// starts at a rotating pointer. A word loads whenever the output register is
// empty or is being drained in the same cycle.
module mux_nx1_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_ok;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [SEL_W-1:0] ptr_next;

    // Round-robin search: first valid channel at ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        int unsigned      c;
        logic [SEL_W-1:0] cidx;
        rr_found = 1'b0;
        rr_idx   = '0;
        c        = 0;
        cidx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            if (c >= N) begin
                c = c - N;
            end
            cidx = SEL_W'(c);
            if (!rr_found && in_valid[cidx]) begin
                rr_found = 1'b1;
                rr_idx   = cidx;
            end
        end
    end

    // Grant selection, per-channel ready, data mux and output register next state.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        if (mode) begin
            grant_ok  = rr_found;
            grant_idx = rr_idx;
        end else if ((int'(sel) < N) && in_valid[sel]) begin
            grant_ok  = 1'b1;
            grant_idx = sel;
        end

        load_en = !valid_q || out_ready;
        xfer    = grant_ok && load_en && !rst;

        in_ready = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            in_ready[k] = xfer && (grant_idx == SEL_W'(k));
            if (grant_idx == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end

        if (int'(grant_idx) + 1 >= N) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end

        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = sel_data;
            chan_d  = grant_idx;
            valid_d = 1'b1;
            if (mode) begin
                ptr_d = ptr_next;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed scenarios followed by random traffic, all compared
// against a cycle-level behavioural model of the multiplexer.
module tb_mux_nx1_rr;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_chan;
    logic                 out_valid;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;

    // Model state
    int       m_valid = 0;
    int       m_data  = 0;
    int       m_chan  = 0;
    int       m_ptr   = 0;
    logic [N-1:0] last_ready;

    mux_nx1_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input int v);
        in_data[ch*WIDTH +: WIDTH] = v[WIDTH-1:0];
    endtask

    // One clock: check ready at the falling edge, advance the model on the
    // rising edge, then check the registered outputs just after it.
    task automatic tick();
        int  load_en;
        int  found;
        int  g;
        int  c;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        load_en = (m_valid == 0 || out_ready) ? 1 : 0;
        found = 0;
        g = 0;
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
                found = 1;
                g = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (found == 0 && in_valid[c]) begin
                    found = 1;
                    g = c;
                end
            end
        end
        exp_ready = '0;
        if (!rst && load_en != 0 && found != 0) exp_ready[g] = 1'b1;
        last_ready = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        end else if (exp_ready != '0) begin
            m_data  = int'(in_data[g*WIDTH +: WIDTH]);
            m_chan  = g;
            m_valid = 1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid != 0 || rst) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        mode = 1'b0; sel = '0;
        for (int i = 0; i < N; i++) set_data(i, 8'h50 + i);

        // Reset with every channel valid and downstream ready
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", 32'(out_data), 32'h00);
            chk("rst_chan", 32'(out_chan), 32'd0);
            chk("rst_ready", 32'(last_ready), 32'b0000);
        end
        rst = 1'b0;

        // Fixed select of channel 2
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; set_data(2, 8'hA5);
        tick();
        chk("fix_ready", 32'(last_ready), 32'b0100);
        chk("fix_data", 32'(out_data), 32'hA5);
        chk("fix_chan", 32'(out_chan), 32'd2);
        chk("fix_valid", 32'(out_valid), 32'd1);
        in_valid = '0;
        tick();

        // Round robin, all valid: 0,1,2,3,0 back to back
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, 8'h10 + i);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_chan", 32'(out_chan), 32'(i % 4));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // Sparse round robin from ptr=0: 1,3,1,3
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sparse_chan", 32'(out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: hold 3C for three stalled cycles, then next word loads
        mode = 1'b0; sel = 3'd0; in_valid = 4'b0001; set_data(0, 8'h3C);
        tick();
        chk("bp_load", 32'(out_data), 32'h3C);
        out_ready = 1'b0; set_data(0, 8'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", 32'(out_data), 32'h3C);
            chk("bp_ready", 32'(last_ready), 32'b0000);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(last_ready), 32'b0001);
        chk("bp_next", 32'(out_data), 32'h77);

        // Out-of-range select: no grant
        sel = 3'd5; in_valid = 4'b1111;
        tick();
        chk("sel5_ready", 32'(last_ready), 32'b0000);
        chk("sel5_valid", 32'(out_valid), 32'd0);

        // Reset while a word is held
        sel = 3'd1;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; out_ready = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, 7));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = (N*WIDTH)'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
